// File: rtl/blink_pkg.sv
// Shared types and default sizing for the blink_pattern player.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } bp_state_t;

    localparam int BP_PLEN      = 8;
    localparam int BP_GAP_TICKS = 4;
    localparam int BP_GCNT_W    = 8;

    function automatic logic bp_is_busy(input bp_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/blink_pattern_sva.sv
// Property checker for blink_pattern; bound in when BLINK_PATTERN_ASSERT_EN is defined.
module blink_pattern_sva (
    input logic clk,
    input logic rst,
    input logic tick_i,
    input logic start_i,
    input logic led_o,
    input logic busy_o,
    input logic done_o
);

    a_done_single: assert property (@(posedge clk) disable iff (rst)
        done_o |=> !done_o);

    a_dark_when_idle: assert property (@(posedge clk) disable iff (rst)
        !busy_o |-> !led_o);

    a_led_after_tick: assert property (@(posedge clk) disable iff (rst)
        (led_o != $past(led_o)) |-> $past(tick_i));

    a_done_after_tick: assert property (@(posedge clk) disable iff (rst)
        done_o |-> $past(tick_i));

    a_start_busy: assert property (@(posedge clk) disable iff (rst)
        (start_i && !busy_o) |=> busy_o);

endmodule

// File: rtl/blink_pattern.sv
// Tick-paced on/off pattern player with a dark gap after each pattern.
// Define BLINK_PATTERN_ASSERT_EN to compile in the blink_pattern_sva checker.
module blink_pattern
    import blink_pkg::*;
#(
    parameter int PLEN      = BP_PLEN,
    parameter int GAP_TICKS = BP_GAP_TICKS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_i,
    input  logic            start_i,
    input  logic            rpt_i,
    input  logic [PLEN-1:0] pattern_i,
    output logic            led_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int IDX_W = $clog2(PLEN);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(PLEN - 1);
    localparam logic [BP_GCNT_W-1:0] GCNT_LAST = BP_GCNT_W'(GAP_TICKS - 1);

    bp_state_t             state_q, state_d;
    logic [PLEN-1:0]       pat_q, pat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BP_GCNT_W-1:0]  gcnt_q, gcnt_d;
    logic                  led_q, led_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= {PLEN{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            gcnt_q  <= {BP_GCNT_W{1'b0}};
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic; everything holds between ticks.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        led_d   = led_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                led_d = 1'b0;
                // A tick coinciding with start is deliberately not consumed.
                if (start_i) begin
                    pat_d   = pattern_i;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (tick_i) begin
                    led_d = pat_q[idx_q];
                    if (idx_q == IDX_LAST) begin
                        idx_d   = {IDX_W{1'b0}};
                        gcnt_d  = {BP_GCNT_W{1'b0}};
                        state_d = GAP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end

            GAP: begin
                if (tick_i) begin
                    led_d = 1'b0;
                    if (gcnt_q == GCNT_LAST) begin
                        done_d = 1'b1;
                        if (rpt_i) begin
                            state_d = RUN;
                            idx_d   = {IDX_W{1'b0}};
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gcnt_d = gcnt_q + 1'b1;
                    end
                end else begin
                    state_d = GAP;
                end
            end

            default: begin
                state_d = IDLE;
                led_d   = 1'b0;
                idx_d   = {IDX_W{1'b0}};
                gcnt_d  = {BP_GCNT_W{1'b0}};
            end
        endcase

        busy_d = bp_is_busy(state_d);
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

`ifdef BLINK_PATTERN_ASSERT_EN
    blink_pattern_sva u_sva (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick_i),
        .start_i (start_i),
        .led_o   (led_q),
        .busy_o  (busy_q),
        .done_o  (done_q)
    );
`else
    // Checker not compiled in this build.
`endif

endmodule

// File: tb/tb_blink_pattern.sv
// Directed self-checking bench for blink_pattern (default sizing and PLEN=2/GAP_TICKS=1).
module tb_blink_pattern;

    logic       clk;
    logic       rst;
    logic       tick, start, rpt;
    logic [7:0] pattern;
    logic       led, busy, done;

    logic       tick2, start2, rpt2;
    logic [1:0] pattern2;
    logic       led2, busy2, done2;

    int checks;
    int failures;

    logic [11:0] single_exp;

    blink_pattern #(.PLEN(8), .GAP_TICKS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick),
        .start_i   (start),
        .rpt_i     (rpt),
        .pattern_i (pattern),
        .led_o     (led),
        .busy_o    (busy),
        .done_o    (done)
    );

    blink_pattern #(.PLEN(2), .GAP_TICKS(1)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (tick2),
        .start_i   (start2),
        .rpt_i     (rpt2),
        .pattern_i (pattern2),
        .led_o     (led2),
        .busy_o    (busy2),
        .done_o    (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_tick2();
        tick2 = 1'b1;
        cyc();
        tick2 = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        start    = 1'b0;
        rpt      = 1'b0;
        pattern  = 8'h00;
        tick2    = 1'b0;
        start2   = 1'b0;
        rpt2     = 1'b0;
        pattern2 = 2'b00;

        // Reset state
        idle(3);
        check("reset_led", {31'd0, led}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        idle(2);
        do_tick();
        check("idle_tick_busy", {31'd0, busy}, 32'd0);

        // Single play of 1011_0001, ticks every 16 cycles
        single_exp = 12'b0000_1011_0001;
        pattern = 8'b1011_0001;
        start = 1'b1;
        cyc();
        start = 1'b0;
        pattern = 8'h00;
        check("single_busy_rise", {31'd0, busy}, 32'd1);
        check("single_led_pre", {31'd0, led}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            do_tick();
            check("single_led", {31'd0, led}, {31'd0, single_exp[i]});
            check("single_done", {31'd0, done}, (i == 11) ? 32'd1 : 32'd0);
            check("single_busy", {31'd0, busy}, (i == 11) ? 32'd0 : 32'd1);
            idle(15);
            check("single_led_hold", {31'd0, led}, {31'd0, single_exp[i]});
            check("single_done_low", {31'd0, done}, 32'd0);
        end

        // Start with coincident tick, then start while busy
        pattern = 8'h01;
        start = 1'b1;
        tick  = 1'b1;
        cyc();
        start = 1'b0;
        tick  = 1'b0;
        check("st_tick_busy", {31'd0, busy}, 32'd1);
        check("st_tick_led", {31'd0, led}, 32'd0);
        idle(3);
        check("st_tick_led_wait", {31'd0, led}, 32'd0);
        do_tick();
        check("st_tick_first_bit", {31'd0, led}, 32'd1);
        do_tick();
        check("st_tick_second_bit", {31'd0, led}, 32'd0);
        pattern = 8'hFF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 3; i <= 12; i++) begin
            do_tick();
            check("busy_start_led", {31'd0, led}, 32'd0);
            check("busy_start_done", {31'd0, done}, (i == 12) ? 32'd1 : 32'd0);
            check("busy_start_busy", {31'd0, busy}, (i == 12) ? 32'd0 : 32'd1);
            cyc();
        end
        check("busy_start_done_clear", {31'd0, done}, 32'd0);

        // Reset mid-RUN after 3 ticks
        pattern = 8'hFF;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) begin
            do_tick();
            cyc();
        end
        check("mid_run_led_before", {31'd0, led}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_led", {31'd0, led}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_tick();
            check("post_rst_done", {31'd0, done}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            check("post_rst_led", {31'd0, led}, 32'd0);
        end

        // Repeat mode with pattern 0x01: two repeating periods, then a final one
        rpt = 1'b1;
        pattern = 8'h01;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) rpt = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                do_tick();
                check("rpt_led", {31'd0, led}, (k == 1) ? 32'd1 : 32'd0);
                check("rpt_done", {31'd0, done}, (k == 12) ? 32'd1 : 32'd0);
                check("rpt_busy", {31'd0, busy}, (p == 2 && k == 12) ? 32'd0 : 32'd1);
                cyc();
                check("rpt_done_clear", {31'd0, done}, 32'd0);
            end
        end

        // Edge sizing: PLEN=2, GAP_TICKS=1, pattern 2'b11
        pattern2 = 2'b11;
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        check("edge_busy", {31'd0, busy2}, 32'd1);
        do_tick2();
        check("edge_led1", {31'd0, led2}, 32'd1);
        cyc();
        do_tick2();
        check("edge_led2", {31'd0, led2}, 32'd1);
        check("edge_done_early", {31'd0, done2}, 32'd0);
        cyc();
        do_tick2();
        check("edge_led_gap", {31'd0, led2}, 32'd0);
        check("edge_done", {31'd0, done2}, 32'd1);
        check("edge_busy_fall", {31'd0, busy2}, 32'd0);
        cyc();
        check("edge_done_clear", {31'd0, done2}, 32'd0);
        do_tick2();
        check("edge_extra_led", {31'd0, led2}, 32'd0);
        check("edge_extra_done", {31'd0, done2}, 32'd0);
        check("edge_extra_busy", {31'd0, busy2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
